// File: rtl/heading_pkg.sv
// Shared types and the quarter-wave sine table for the ship-heading controller.
// The vector helper turns a heading index into the signed (dx, dy) unit-vector components.
package heading_pkg;

  localparam int DIR_BITS_MIN = 2;
  localparam int DIR_BITS_MAX = 6;
  localparam int MAG_BITS_MIN = 1;
  localparam int MAG_BITS_MAX = 8;
  localparam int SINE_ENTRIES = 17;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } heading_state_e;

  // round(255 * sin(k * 90deg / 16)) for k = 0..16
  function automatic int quarter_sine(input int k);
    case (k)
      0:       return 0;
      1:       return 25;
      2:       return 50;
      3:       return 74;
      4:       return 98;
      5:       return 120;
      6:       return 142;
      7:       return 162;
      8:       return 180;
      9:       return 197;
      10:      return 212;
      11:      return 225;
      12:      return 236;
      13:      return 244;
      14:      return 250;
      15:      return 254;
      default: return 255;
    endcase
  endfunction

  // Screen coordinates: x grows right, y grows down, heading 0 points up.
  function automatic int vec_component(input int h, input int dir_bits,
                                       input int mag_bits, input bit want_y);
    int quarter;
    int idx;
    int quad;
    int s_mag;
    int c_mag;
    int x;
    int y;
    quarter = (1 << dir_bits) / 4;
    idx     = (h % quarter) * (16 / quarter);
    quad    = (h / quarter) % 4;
    s_mag   = quarter_sine(idx) >> (8 - mag_bits);
    c_mag   = quarter_sine(16 - idx) >> (8 - mag_bits);
    case (quad)
      0:       begin x =  s_mag; y = -c_mag; end
      1:       begin x =  c_mag; y =  s_mag; end
      2:       begin x = -s_mag; y =  c_mag; end
      default: begin x = -c_mag; y = -s_mag; end
    endcase
    return want_y ? y : x;
  endfunction

endpackage

// File: rtl/heading_vector_lut.sv
// Registered heading -> (dx, dy) lookup; outputs trail the heading index by one cycle.
// Reset loads the vector of the reset heading so outputs are consistent straight out of reset.
module heading_vector_lut
  import heading_pkg::*;
#(
  parameter int DIR_BITS      = 5,
  parameter int MAG_BITS      = 7,
  parameter int RESET_HEADING = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [DIR_BITS-1:0]        heading_i,
  output logic signed [MAG_BITS:0]   dx_o,
  output logic signed [MAG_BITS:0]   dy_o
);

  localparam int VW = MAG_BITS + 1;
  localparam logic signed [MAG_BITS:0] RST_DX =
    VW'(vec_component(RESET_HEADING, DIR_BITS, MAG_BITS, 1'b0));
  localparam logic signed [MAG_BITS:0] RST_DY =
    VW'(vec_component(RESET_HEADING, DIR_BITS, MAG_BITS, 1'b1));

  logic signed [MAG_BITS:0] dx_d;
  logic signed [MAG_BITS:0] dy_d;
  logic signed [MAG_BITS:0] dx_q;
  logic signed [MAG_BITS:0] dy_q;

  always_comb begin
    dx_d = VW'(vec_component(int'(heading_i), DIR_BITS, MAG_BITS, 1'b0));
    dy_d = VW'(vec_component(int'(heading_i), DIR_BITS, MAG_BITS, 1'b1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dx_q <= RST_DX;
      dy_q <= RST_DY;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign dx_o = dx_q;
  assign dy_o = dy_q;

endmodule

// File: rtl/heading_rotator.sv
// Ship-heading controller: tick-gated left/right stepping with hold-to-repeat, direct load,
// and a registered unit vector for the position integrator.
module heading_rotator
  import heading_pkg::*;
#(
  parameter int DIR_BITS      = 5,
  parameter int MAG_BITS      = 7,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_RATE   = 2,
  parameter int RESET_HEADING = 0
) (
  input  logic                      moveClock,
  input  logic                      resetn,
  input  logic                      tick,
  input  logic                      left,
  input  logic                      right,
  input  logic                      load,
  input  logic [DIR_BITS-1:0]       loadHeading,
  output logic [DIR_BITS-1:0]       heading,
  output logic signed [MAG_BITS:0]  dx,
  output logic signed [MAG_BITS:0]  dy,
  output logic                      turned,
  output heading_state_e            dbg_state
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]    CNT_DELAY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0]    CNT_RATE  = CNT_W'(REPEAT_RATE);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [DIR_BITS-1:0] HEAD_RST  = DIR_BITS'(RESET_HEADING);

  heading_state_e      state_q;
  heading_state_e      state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [DIR_BITS-1:0] heading_q;
  logic [DIR_BITS-1:0] heading_d;
  logic                last_right_q;
  logic                last_right_d;
  logic                turned_q;
  logic                turned_d;
  logic                one_btn;
  logic                step;

  assign one_btn = left ^ right;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_right_d = last_right_q;
    step         = 1'b0;
    if (load) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (tick) begin
      if (!one_btn) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            step    = 1'b1;
            state_d = ST_HOLD;
            cnt_d   = CNT_DELAY;
          end
          // A direction reversal restarts the hold delay with an immediate step.
          ST_HOLD, ST_REPEAT: begin
            if (right != last_right_q) begin
              step    = 1'b1;
              state_d = ST_HOLD;
              cnt_d   = CNT_DELAY;
            end else if (cnt_q == CNT_ONE) begin
              step    = 1'b1;
              state_d = ST_REPEAT;
              cnt_d   = CNT_RATE;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    turned_d = step;
    if (step) begin
      last_right_d = right;
    end

    if (load) begin
      heading_d = loadHeading;
    end else if (step) begin
      heading_d = right ? (heading_q + DIR_BITS'(1)) : (heading_q - DIR_BITS'(1));
    end else begin
      heading_d = heading_q;
    end
  end

  always_ff @(posedge moveClock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      heading_q    <= HEAD_RST;
      last_right_q <= 1'b0;
      turned_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      heading_q    <= heading_d;
      last_right_q <= last_right_d;
      turned_q     <= turned_d;
    end
  end

  heading_vector_lut #(
    .DIR_BITS      (DIR_BITS),
    .MAG_BITS      (MAG_BITS),
    .RESET_HEADING (RESET_HEADING)
  ) u_vec (
    .clk_i     (moveClock),
    .rst_ni    (resetn),
    .heading_i (heading_q),
    .dx_o      (dx),
    .dy_o      (dy)
  );

  assign heading   = heading_q;
  assign turned    = turned_q;
  assign dbg_state = state_q;

endmodule
